reg_dump_reader: RTL and testbench

// - Reader/initiator for the pipeline's register debug port: drives regNo, samples val, streams register contents out.
// - Walks a requested register range, one word per beat, on a valid/ready stream (debug UART/JTAG bridge, testbench scoreboard).
// - Sits beside the pipeline top level. Its only coupling to the pipeline is regNo/val; it never stalls the core.

---
 rtl/reg_dump_reader_pkg.sv | 24 ++
 rtl/reg_dump_reader_beat.sv | 35 +++
 rtl/reg_dump_reader.sv | 164 ++++++++++++++++
 tb/tb_reg_dump_reader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared types and helpers for the register dump reader: defaults, FSM encoding,
// and the index-advance rule (wraps modulo the register count, optionally skipping r0).
package reg_dump_reader_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic int next_idx(input int idx, input int aw, input bit skip_r0);
        int n;
        n = (idx + 1) & ((1 << aw) - 1);
        if (skip_r0 && (n == 0)) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_dump_reader_beat.sv
// Output beat holding register: loads one register sample and holds it until the sink takes it.
module dump_beat_reg #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_take,
    input  logic [DATA_W-1:0] i_data,
    input  logic [REG_AW-1:0] i_idx,
    input  logic              i_last,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [REG_AW-1:0] o_idx,
    output logic              o_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_idx   <= i_idx;
            o_last  <= i_last;
        end else if (i_take) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a register index range over the pipeline debug port (reg_no -> val) and
// streams each value out as one valid/ready beat, with abort and wrap-around.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 0,
    parameter int SKIP_R0  = 0
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              dump_req,
    input  logic [REG_AW-1:0] first_reg,
    input  logic [REG_AW-1:0] last_reg,
    input  logic              abort,
    output logic [REG_AW-1:0] reg_no,
    input  logic [DATA_W-1:0] val,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [REG_AW-1:0] dump_idx,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    state_t            r_state, r_state_next;
    logic [REG_AW-1:0] r_cur, r_cur_next;
    logic [REG_AW-1:0] r_last, r_last_next;
    logic [REG_AW-1:0] r_reg_no, r_reg_no_next;
    logic [1:0]        r_wait, r_wait_next;
    logic              r_abort_seen, r_abort_seen_next;
    logic              r_empty, r_empty_next;
    logic              r_busy, r_busy_next;
    logic              r_done, r_done_next;
    logic              r_aborted, r_aborted_next;

    logic              w_load;
    logic              w_hs;
    logic [REG_AW-1:0] w_next_cur;
    logic              w_skip;

    assign w_skip     = (SKIP_R0 != 0);
    assign w_hs       = dump_valid & dump_ready;
    assign w_next_cur = REG_AW'(next_idx(int'(r_cur), REG_AW, w_skip));

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            r_state      <= ST_IDLE;
            r_cur        <= '0;
            r_last       <= '0;
            r_reg_no     <= '0;
            r_wait       <= '0;
            r_abort_seen <= 1'b0;
            r_empty      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= r_state_next;
            r_cur        <= r_cur_next;
            r_last       <= r_last_next;
            r_reg_no     <= r_reg_no_next;
            r_wait       <= r_wait_next;
            r_abort_seen <= r_abort_seen_next;
            r_empty      <= r_empty_next;
            r_busy       <= r_busy_next;
            r_done       <= r_done_next;
            r_aborted    <= r_aborted_next;
        end
    end

    always_comb begin
        r_state_next      = r_state;
        r_cur_next        = r_cur;
        r_last_next       = r_last;
        r_reg_no_next     = r_reg_no;
        r_wait_next       = r_wait;
        r_abort_seen_next = r_abort_seen;
        r_empty_next      = r_empty;
        r_done_next       = 1'b0;
        r_aborted_next    = 1'b0;
        w_load            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (dump_req) begin
                    // With r0 skipped, a range ending at 0 really ends at the top index.
                    r_last_next       = (w_skip && (last_reg == '0)) ? '1 : last_reg;
                    r_empty_next      = w_skip && (first_reg == '0) && (last_reg == '0);
                    r_cur_next        = (w_skip && (first_reg == '0)) ? REG_AW'(1) : first_reg;
                    r_reg_no_next     = r_cur_next;
                    r_wait_next       = '0;
                    r_abort_seen_next = 1'b0;
                    r_state_next      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (abort) begin
                    r_abort_seen_next = 1'b1;
                end
                if (r_empty) begin
                    r_done_next  = 1'b1;
                    r_state_next = ST_FIN;
                end else if (r_wait == 2'(READ_LAT)) begin
                    w_load       = 1'b1;
                    r_state_next = ST_SEND;
                end else begin
                    r_wait_next = r_wait + 2'd1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    r_abort_seen_next = 1'b1;
                end
                if (w_hs) begin
                    if (dump_last) begin
                        r_done_next  = 1'b1;
                        r_state_next = ST_FIN;
                    end else if (r_abort_seen || abort) begin
                        r_done_next    = 1'b1;
                        r_aborted_next = 1'b1;
                        r_state_next   = ST_FIN;
                    end else begin
                        r_cur_next    = w_next_cur;
                        r_reg_no_next = w_next_cur;
                        r_wait_next   = '0;
                        r_state_next  = ST_ADDR;
                    end
                end
            end
            default: begin
                r_state_next = ST_IDLE;
            end
        endcase

        r_busy_next = (r_state_next != ST_IDLE);
    end

    dump_beat_reg #(
        .REG_AW (REG_AW),
        .DATA_W (DATA_W)
    ) u_beat (
        .clk     (clk),
        .rst_n   (startin),
        .i_load  (w_load),
        .i_take  (w_hs),
        .i_data  (val),
        .i_idx   (r_cur),
        .i_last  (r_cur == r_last),
        .o_valid (dump_valid),
        .o_data  (dump_data),
        .o_idx   (dump_idx),
        .o_last  (dump_last)
    );

    assign reg_no  = r_reg_no;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a plain and an r0-skipping instance share stimulus.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        startin;
    logic        dump_req;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic        abort;
    logic        dump_ready;

    logic [4:0]  reg_no,     reg_no_s;
    logic [31:0] val,        val_s;
    logic        dump_valid, dump_valid_s;
    logic [31:0] dump_data,  dump_data_s;
    logic [4:0]  dump_idx,   dump_idx_s;
    logic        dump_last,  dump_last_s;
    logic        busy,       busy_s;
    logic        done,       done_s;
    logic        aborted,    aborted_s;

    logic [31:0] regs [32];

    int n_chk = 0;
    int n_err = 0;

    int q_idx  [$];
    int q_data [$];
    int q_last [$];
    int got_done;
    int got_aborted;
    int gap;

    always #5 clk = ~clk;

    assign val   = regs[reg_no];
    assign val_s = regs[reg_no_s];

    reg_dump_reader #(.REG_AW(5), .DATA_W(32), .READ_LAT(0), .SKIP_R0(0)) u_dut (
        .clk(clk), .startin(startin), .dump_req(dump_req), .first_reg(first_reg),
        .last_reg(last_reg), .abort(abort), .reg_no(reg_no), .val(val),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_idx(dump_idx), .dump_last(dump_last), .busy(busy), .done(done),
        .aborted(aborted)
    );

    reg_dump_reader #(.REG_AW(5), .DATA_W(32), .READ_LAT(0), .SKIP_R0(1)) u_dut_s (
        .clk(clk), .startin(startin), .dump_req(dump_req), .first_reg(first_reg),
        .last_reg(last_reg), .abort(abort), .reg_no(reg_no_s), .val(val_s),
        .dump_valid(dump_valid_s), .dump_ready(dump_ready), .dump_data(dump_data_s),
        .dump_idx(dump_idx_s), .dump_last(dump_last_s), .busy(busy_s), .done(done_s),
        .aborted(aborted_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (busy || busy_s); i++) @(negedge clk);
    endtask

    // One dump on the plain instance; stall_beat/abort_beat select a beat by its position (-1: none).
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int stall_beat, input int abort_beat);
        int stall_cnt;
        int hs_cyc;
        q_idx.delete(); q_data.delete(); q_last.delete();
        wait_idle();
        first_reg = f;
        last_reg  = l;
        dump_req  = 1'b1;
        @(negedge clk);
        dump_req    = 1'b0;
        stall_cnt   = 0;
        hs_cyc      = -100;
        got_done    = 0;
        got_aborted = 0;
        gap         = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                got_done    = 1;
                got_aborted = int'(aborted);
                gap         = cyc - hs_cyc;
                break;
            end
            abort = dump_valid && (q_idx.size() == abort_beat);
            if (dump_valid && (q_idx.size() == stall_beat) && (stall_cnt < 5)) begin
                dump_ready = 1'b0;
                stall_cnt++;
                chk("stall_valid", 32'(dump_valid), 32'd1);
                chk("stall_idx",   32'(dump_idx),   32'd2);
                chk("stall_data",  dump_data,       32'h22);
            end else begin
                dump_ready = 1'b1;
            end
            if (dump_valid && dump_ready) begin
                q_idx.push_back(int'(dump_idx));
                q_data.push_back(int'(dump_data));
                q_last.push_back(int'(dump_last));
                hs_cyc = cyc;
            end
            @(negedge clk);
        end
        abort      = 1'b0;
        dump_ready = 1'b1;
        chk("done_seen", 32'(got_done), 32'd1);
        chk("done_gap",  32'(gap),      32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    // Expected beats: idx (f+k) mod 32, data 0x11*idx, last only on the final beat when ends_last.
    task automatic verify_beats(input int f, input int n, input int ends_last, input int exp_ab);
        int e_idx;
        chk("beat_count", 32'(q_idx.size()), 32'(n));
        chk("aborted",    32'(got_aborted),  32'(exp_ab));
        for (int k = 0; k < n && k < q_idx.size(); k++) begin
            e_idx = (f + k) % 32;
            chk("beat_idx",  32'(q_idx[k]),  32'(e_idx));
            chk("beat_data", 32'(q_data[k]), 32'h11 * 32'(e_idx));
            chk("beat_last", 32'(q_last[k]), ((k == n - 1) && (ends_last != 0)) ? 32'd1 : 32'd0);
        end
        $display("dump first=%0d beats=%0d aborted=%0d", f, q_idx.size(), got_aborted);
    endtask

    initial begin
        int done_cyc;
        int saw_valid;
        for (int i = 0; i < 32; i++) regs[i] = 32'h11 * 32'(i);
        startin    = 1'b0;
        dump_req   = 1'b0;
        first_reg  = '0;
        last_reg   = '0;
        abort      = 1'b0;
        dump_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid",   32'(dump_valid), 32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_done",    32'(done),       32'd0);
        chk("rst_aborted", 32'(aborted),    32'd0);
        chk("rst_reg_no",  32'(reg_no),     32'd0);
        chk("rst_data",    dump_data,       32'd0);
        startin = 1'b1;
        @(negedge clk);

        // Plain range with ready high.
        run_dump(5'd1, 5'd3, -1, -1);
        verify_beats(1, 3, 1, 0);

        // Wrap-around walk 30,31,0,1.
        run_dump(5'd30, 5'd1, -1, -1);
        verify_beats(30, 4, 1, 0);

        // Backpressure on the second beat.
        run_dump(5'd1, 5'd3, 1, -1);
        verify_beats(1, 3, 1, 0);

        // Abort while beat idx 4 is on offer.
        run_dump(5'd0, 5'd31, -1, 4);
        verify_beats(0, 5, 0, 1);

        // Single-register range.
        run_dump(5'd7, 5'd7, -1, -1);
        verify_beats(7, 1, 1, 0);

        // Skip instance with an r0-only range: no beats, prompt clean done.
        wait_idle();
        first_reg = 5'd0;
        last_reg  = 5'd0;
        dump_req  = 1'b1;
        @(negedge clk);
        dump_req  = 1'b0;
        done_cyc  = -1;
        saw_valid = 0;
        for (int i = 0; i < 6; i++) begin
            if (dump_valid_s) saw_valid = 1;
            if (done_s && done_cyc < 0) begin
                done_cyc = i;
                chk("skip_aborted", 32'(aborted_s), 32'd0);
            end
            @(negedge clk);
        end
        chk("skip_no_valid", 32'(saw_valid), 32'd0);
        chk("skip_done_by3", 32'((done_cyc >= 0) && (done_cyc <= 2)), 32'd1);
        $display("skip r0-only: done at cycle %0d valid_seen=%0d", done_cyc, saw_valid);

        // Reset while a beat sits in SEND.
        wait_idle();
        first_reg  = 5'd1;
        last_reg   = 5'd3;
        dump_ready = 1'b0;
        dump_req   = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        for (int i = 0; i < 10 && !dump_valid; i++) @(negedge clk);
        chk("pre_rst_valid", 32'(dump_valid), 32'd1);
        #2 startin = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(dump_valid), 32'd0);
        chk("mid_rst_busy",   32'(busy),       32'd0);
        chk("mid_rst_done",   32'(done),       32'd0);
        chk("mid_rst_reg_no", 32'(reg_no),     32'd0);
        chk("mid_rst_idx",    32'(dump_idx),   32'd0);
        $display("reset in SEND: valid=%0d busy=%0d done=%0d", dump_valid, busy, done);
        @(negedge clk);
        startin    = 1'b1;
        dump_ready = 1'b1;
        @(negedge clk);
        run_dump(5'd1, 5'd3, -1, -1);
        verify_beats(1, 3, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
